// File: rtl/core_pkg.sv
// core_pkg: shared fetch FSM state and prefetch FIFO entry types
package core_pkg;
  typedef enum logic [1:0] {IDLE, REQ, REQ_FLUSH} fetch_state_e;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } fifo_entry_t;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: flushable FIFO of fetched instruction words with occupancy count
module ifu_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fifo_entry_t            wdata,
  output fifo_entry_t            head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fifo_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/ifu_prefetch_buffer.sv
// ifu_prefetch_buffer: sequential instruction prefetcher with redirect flush
module ifu_prefetch_buffer
  import core_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);
  fetch_state_e state, state_n;
  logic [31:0] fetch_addr, fetch_addr_n, stale_addr, resp_addr, target;
  logic [CW-1:0] outstanding, out_n, discard, discard_n, count, cnt_n;
  logic gnt, pending, push, pop, space_ok;
  fifo_entry_t head, wdata;
  assign target       = addr_i & ~32'h3;
  assign instr_req_o  = state != IDLE;
  // a request caught ungranted by a redirect keeps showing its old address
  assign instr_addr_o = state == REQ_FLUSH ? stale_addr : fetch_addr;
  assign busy_o       = instr_req_o | (outstanding != '0);
  assign valid_o      = count != '0;
  assign {addr_o, rdata_o, err_o} = head;
  assign gnt     = instr_req_o & instr_gnt_i;
  assign pending = instr_req_o & ~instr_gnt_i;
  assign pop     = valid_o & ready_i & ~branch_i;
  assign push    = instr_rvalid_i & (discard == '0) & ~branch_i;
  assign wdata   = {resp_addr, instr_rdata_i, instr_err_i};
  always_comb begin
    out_n        = outstanding + CW'(gnt) - CW'(instr_rvalid_i);
    cnt_n        = branch_i ? '0 : count + CW'(push) - CW'(pop);
    space_ok     = (cnt_n + out_n < DEPTH_C) && (out_n < MAX_C);
    state_n      = pending ? (branch_i ? REQ_FLUSH : state) : (req_i && space_ok ? REQ : IDLE);
    fetch_addr_n = branch_i ? target : fetch_addr + (gnt && state == REQ ? 32'd4 : 32'd0);
    discard_n    = branch_i ? out_n + CW'(pending) : discard - CW'(instr_rvalid_i && discard != '0);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      fetch_addr  <= '0;
      stale_addr  <= '0;
      resp_addr   <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_n;
      fetch_addr  <= fetch_addr_n;
      outstanding <= out_n;
      discard     <= discard_n;
      resp_addr   <= branch_i ? target : resp_addr + (push ? 32'd4 : 32'd0);
      if (branch_i && pending && state == REQ) stale_addr <= fetch_addr;
    end
  end
  ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (push),
    .pop   (pop),
    .flush (branch_i),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );
endmodule

// File: tb/tb_ifu_prefetch_buffer.sv
// tb_ifu_prefetch_buffer: queue-based reference model with per-cycle compare plus directed scenarios
module tb_ifu_prefetch_buffer;
  import core_pkg::*;
  localparam int DEPTH = 4, MAXO = 2;
  logic clk = 0, rst_n = 1;
  logic req = 0, branch = 0, ready = 0, gnt = 0, rvalid = 0, err_in = 0;
  logic [31:0] addr_in = '0, rdata_in = '0;
  logic valid_o, err_o, busy_o, instr_req_o;
  logic [31:0] rdata_o, addr_o, instr_addr_o;
  typedef struct {logic [31:0] addr; logic stale;} fl_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; logic err;} ent_t;
  fl_t infl[$];
  ent_t fq[$];
  logic [31:0] bus_q[$];
  logic p = 0, p_stale = 0, req_s;
  logic [31:0] pa = 0, nxt = 0, addr_s, last_gnt = 0, first_head = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [31:0] seq [3];
  int passed = 0, total = 0, ngrant = 0, fr, fv, ns;
  bit chk_en = 0, err_en = 0;

  ifu_prefetch_buffer dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .branch_i(branch), .addr_i(addr_in),
    .ready_i(ready), .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o), .err_o(err_o),
    .busy_o(busy_o), .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(gnt), .instr_rvalid_i(rvalid), .instr_rdata_i(rdata_in), .instr_err_i(err_in)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic err_of(logic [31:0] a);
    return a == err_addr || (err_en && a[6:2] == 5'd3);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: every request is tracked as an in-flight address; a redirect marks all of them stale.
  function automatic void model_update();
    fl_t f;
    if (ready && fq.size() > 0 && !branch) void'(fq.pop_front());
    if (rvalid && infl.size() > 0) begin
      f = infl.pop_front();
      if (!branch && !f.stale) fq.push_back('{f.addr, mem_word(f.addr), err_of(f.addr)});
    end
    if (branch) fq.delete();
    if (p && gnt) begin
      infl.push_back('{pa, p_stale});
      if (!p_stale) nxt = nxt + 32'd4;
    end
    if (branch) begin
      foreach (infl[i]) infl[i].stale = 1'b1;
      nxt = addr_in & ~32'h3;
    end
    if (p && !gnt) begin
      if (branch) p_stale = 1'b1;
    end else begin
      p = req && (fq.size() + infl.size() < DEPTH) && (infl.size() < MAXO);
      pa = nxt;
      p_stale = 1'b0;
    end
  endfunction

  always @(negedge clk) if (chk_en) begin
    chk("instr_req", 32'(instr_req_o), 32'(p));
    if (p) chk("instr_addr", instr_addr_o, pa);
    chk("valid", 32'(valid_o), 32'(fq.size() > 0));
    if (fq.size() > 0) begin
      chk("addr", addr_o, fq[0].addr);
      chk("rdata", rdata_o, fq[0].data);
      chk("err", 32'(err_o), 32'(fq[0].err));
    end
    chk("busy", 32'(busy_o), 32'(p || infl.size() > 0));
  end

  task automatic step(int gp, int rp);
    gnt = $urandom_range(99) < gp;
    rvalid = bus_q.size() > 0 && $urandom_range(99) < rp;
    rdata_in = $urandom;
    err_in = 0;
    if (rvalid) begin
      rdata_in = mem_word(bus_q[0]);
      err_in = err_of(bus_q[0]);
    end
    req_s = instr_req_o;
    addr_s = instr_addr_o;
    @(posedge clk); #1;
    if (rvalid) void'(bus_q.pop_front());
    if (req_s && gnt) begin
      bus_q.push_back(addr_s);
      ngrant++;
      last_gnt = addr_s;
    end
    model_update();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    chk_en = 0; req = 0; branch = 0; ready = 0; gnt = 0; rvalid = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_req", 32'(instr_req_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_instr_addr", instr_addr_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_err", 32'(err_o), 0);
    p = 0; p_stale = 0; pa = 0; nxt = 0; ngrant = 0;
    infl.delete(); fq.delete(); bus_q.delete();
    @(negedge clk); #1;
    rst_n = 1;
    chk_en = 1;
  endtask

  initial begin
    do_reset();
    req = 1; ready = 1; fr = -1; fv = -1; ns = 0;
    for (int c = 0; c < 16; c++) begin
      step(100, 100);
      if (instr_req_o && ns < 3) begin seq[ns] = instr_addr_o; ns++; end
      if (instr_req_o && fr < 0) fr = c;
      if (valid_o && fv < 0) begin fv = c; first_head = addr_o; end
    end
    chk("seq0", seq[0], 32'h0);
    chk("seq1", seq[1], 32'h4);
    chk("seq2", seq[2], 32'h8);
    chk("latency", 32'(fv - fr), 2);
    chk("first_head", first_head, 32'h0);
    repeat (3) step(100, 0);
    chk("two_outstanding", 32'(bus_q.size()), 2);
    do_reset();
    err_addr = 32'h4; req = 1; ready = 0;
    step(100, 100);
    chk("restart_addr", instr_addr_o, 32'h0);
    repeat (11) step(100, 100);
    chk("fill_grants", 32'(ngrant), 4);
    chk("fill_req", 32'(instr_req_o), 0);
    chk("fill_valid", 32'(valid_o), 1);
    chk("fill_head", addr_o, 32'h0);
    ready = 1; step(100, 100); ready = 0;
    chk("err_head_addr", addr_o, 32'h4);
    chk("err_head_flag", 32'(err_o), 1);
    repeat (6) step(100, 100);
    chk("refill_grants", 32'(ngrant), 5);
    chk("refill_addr", last_gnt, 32'h10);
    ready = 1; step(100, 100); ready = 0;
    chk("after_err_addr", addr_o, 32'h8);
    chk("after_err_flag", 32'(err_o), 0);
    err_addr = 32'hFFFF_FFFF;
    do_reset();
    req = 1; ready = 1;
    repeat (3) step(100, 0);
    branch = 1; addr_in = 32'h102;
    step(100, 100);
    branch = 0;
    for (int i = 0; i < 20 && !valid_o; i++) step(100, 100);
    chk("br_valid", 32'(valid_o), 1);
    chk("br_addr", addr_o, 32'h100);
    chk("br_data", rdata_o, mem_word(32'h100));
    do_reset();
    req = 1; ready = 1;
    for (int i = 0; i < 40 && !(instr_req_o && instr_addr_o == 32'h20); i++) step(100, 100);
    branch = 1; addr_in = 32'h200;
    step(0, 100);
    branch = 0;
    step(0, 100);
    step(0, 100);
    chk("hold_req", 32'(instr_req_o), 1);
    chk("hold_addr", instr_addr_o, 32'h20);
    step(100, 100);
    chk("target_addr", instr_addr_o, 32'h200);
    for (int i = 0; i < 20 && !valid_o; i++) step(100, 100);
    chk("target_head", addr_o, 32'h200);
    do_reset();
    err_en = 1;
    for (int c = 0; c < 4000; c++) begin
      req = $urandom_range(9) != 0;
      ready = $urandom_range(9) < 7;
      branch = $urandom_range(19) == 0;
      addr_in = $urandom_range(3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      step(60, 60);
    end
    branch = 0; req = 0; ready = 1;
    repeat (20) step(100, 100);
    chk("drained_busy", 32'(busy_o), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
